gau_weight_unit: RTL and testbench
==================================

# gau_weight_unit

Programmable, pipelined Gaussian weighting unit for the SIFT descriptor stage. It replaces the fixed 16x16 combinational weight table with a run-time-loadable WIN x WIN weight table. It also multiplies each incoming gradient magnitude by the weight at its window position (x, y), rounds the product, and shifts it down. It sits between gradient magnitude/orientation generation and histogram accumulation, with valid/ready on both sides.

## Interface
- WIN, 16: window side length; even, 4..32
- WW, 8: weight width (unsigned)
- MW, 16: magnitude width (unsigned)
- SHIFT, 4: right shift applied to the product; 0..WW
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  pulse: begin (re)loading the table
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  WW  next table entry, row-major (y outer, x inner)
- cfg_ready  out  1  table accepts cfg_data
- tbl_loaded  out  1  table fully loaded, unit operational
- in_valid / in_ready  in / out  1  input handshake
- in_x, in_y  in  $clog2(WIN)  position in window
- in_mag  in  MW  gradient magnitude
- in_last  in  1  sideband; passed through aligned with data
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  MW+WW-SHIFT  weighted magnitude
- out_last  out  1  aligned in_last

## Operation
- Table storage: register array of NENT entries, each WW bits, asynchronously cleared to 0. NENT = WIN*WIN, or (WIN/2)^2 under symmetry (see Configuration).
- FSM states:
  - EMPTY (reset state): cfg_ready=0, in_ready=0. On cfg_start, go to LOAD with write pointer = 0.
  - LOAD: cfg_ready=1. Each cfg_valid cycle writes entry[ptr] and increments ptr. The write with ptr==NENT-1 goes to READY. cfg_start in LOAD restarts with ptr=0.
  - READY: tbl_loaded=1, and input is accepted. On cfg_start: go to LOAD if the pipeline is empty, otherwise go to DRAIN.
  - DRAIN: in_ready=0 and tbl_loaded=0. Go to LOAD (ptr=0) once both pipeline stages are empty.
- cfg_start while in EMPTY, READY, or DRAIN is acted on as listed above. In DRAIN, a repeated cfg_start is ignored.
- Address, full table: addr = in_y*WIN + in_x.
- Pipeline: global enable en = !out_valid || out_ready.
  - S1 registers the looked-up weight, in_mag, in_last, and a valid bit.
  - S2 registers out_data = (mag*w + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT, computed at full width MW+WW and then truncated (never overflows). It also registers out_last and out_valid.
- in_ready = (state==READY) && en.
- Weight value 0 yields out_data 0 and is still emitted.

## Timing
- Latency is 2 cycles from the accepting in_valid&&in_ready edge to out_valid.
- Throughput is 1 per cycle when out_ready=1.
- Stall: when out_valid && !out_ready, both stages hold, and out_data/out_last stay stable until accepted.
- Table writes take effect the cycle after the write. No read-during-write is possible, because in_ready=0 outside READY.
- Reset values: cfg_ready=0, tbl_loaded=0, in_ready=0, out_valid=0, out_data=0, out_last=0, all table entries 0, state EMPTY.
- Reset asserted mid-load or mid-stream drops everything in flight, and the table must be reloaded.

## Configuration
- GAU_SYMM_EN defined: only the top-left quadrant is stored, so NENT=(WIN/2)^2 and loading is row-major over the quadrant.
  - Folding: xf = in_x<WIN/2 ? in_x : WIN-1-in_x; yf likewise.
  - addr = yf*(WIN/2)+xf.
  - Fold logic is part of S1 and adds no cycle.
- GAU_SYMM_EN undefined: full WIN*WIN table with no folding.

## Structure
- Package gau_pkg holds:
  - localparams for default WIN/WW/MW/SHIFT;
  - the state enum typedef gau_state_e (EMPTY, LOAD, READY, DRAIN);
  - function gau_fold(idx, win) used by the GAU_SYMM_EN path.
- One sub-module, gau_weight_tbl, contains the storage array, write pointer, and combinational read port. The FSM and pipeline stay in the top module.

## Test plan
- Reset, then in_valid=1 with no load: in_ready stays 0, out_valid=0, tbl_loaded=0.
- Full table (macro off), entry k = k mod 256, then mag=100, x=3, y=2: w=35, out_data=(3500+8)>>4=219, 2 cycles after acceptance.
- Back-to-back stream of 16 inputs with out_ready toggling 1,0,0,1: no loss or duplication, out_data held stable while stalled, out_last on the 16th output only.
- GAU_SYMM_EN, quadrant entry k = k+1 (64 writes): (x,y)=(0,0) and (15,15) both use w=1, (7,7) and (8,8) both use w=64; mag=16 gives 1 and 64 respectively.
- cfg_start with 2 items in flight: state goes to DRAIN, both items delivered, then LOAD. Inputs are refused until the reload completes, and the new weights apply afterwards.
- rst_n asserted mid-load (ptr=100): all outputs return to reset values, and a fresh full load succeeds.

Source files
------------

// File: rtl/gau_pkg.sv
// Shared defaults, FSM state type and the window-fold helper for the Gaussian weighting unit.
package gau_pkg;

  localparam int GAU_WIN   = 16;
  localparam int GAU_WW    = 8;
  localparam int GAU_MW    = 16;
  localparam int GAU_SHIFT = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } gau_state_e;

  // Mirror a window coordinate onto the top-left quadrant.
  function automatic int gau_fold(input int idx, input int win);
    return (idx < win / 2) ? idx : win - 1 - idx;
  endfunction

endpackage

// File: rtl/gau_weight_tbl.sv
// Run-time loadable weight table: sequential write pointer, async-cleared storage, combinational read.
module gau_weight_tbl #(
  parameter int NENT = 256,
  parameter int WW   = 8,
  parameter int AW   = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [WW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o,
  output logic          wlast_o
);

  logic [WW-1:0] tbl_q [NENT];
  logic [AW-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
      for (int i = 0; i < NENT; i++) tbl_q[i] <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (we_i) begin
      tbl_q[ptr_q] <= wdata_i;
      ptr_q        <= ptr_q + 1'b1;
    end
  end

  assign rdata_o = tbl_q[raddr_i];
  assign wlast_o = (ptr_q == AW'(NENT - 1));

endmodule

// File: rtl/gau_weight_unit.sv
// Pipelined Gaussian weighting: table lookup (S1) then round/shift multiply (S2).
// Define GAU_SYMM_EN to store only the top-left quadrant and fold (x, y) onto it.
module gau_weight_unit
  import gau_pkg::*;
#(
  parameter int WIN   = GAU_WIN,
  parameter int WW    = GAU_WW,
  parameter int MW    = GAU_MW,
  parameter int SHIFT = GAU_SHIFT,
  localparam int XW   = $clog2(WIN),
  localparam int OW   = MW + WW - SHIFT
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cfg_start_i,
  input  logic          cfg_valid_i,
  input  logic [WW-1:0] cfg_data_i,
  output logic          cfg_ready_o,
  output logic          tbl_loaded_o,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [XW-1:0] in_x_i,
  input  logic [XW-1:0] in_y_i,
  input  logic [MW-1:0] in_mag_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [OW-1:0] out_data_o,
  output logic          out_last_o
);

`ifdef GAU_SYMM_EN
  localparam int NENT = (WIN / 2) * (WIN / 2);
`else
  localparam int NENT = WIN * WIN;
`endif
  localparam int AW = $clog2(NENT);
  localparam int PW = MW + WW;
  localparam logic [PW-1:0] RND = (SHIFT > 0) ? (PW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  gau_state_e    state_q, state_d;
  logic          tbl_clr, tbl_we, tbl_wlast, acc_ok;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_w;

  logic          s1_vld_q, s1_last_q, out_vld_q, out_last_q;
  logic [WW-1:0] s1_w_q;
  logic [MW-1:0] s1_mag_q;
  logic [OW-1:0] out_data_q, out_data_d;
  logic [PW-1:0] prod;
  logic          en, pipe_empty;

  assign en         = !out_vld_q || out_ready_i;
  assign pipe_empty = !s1_vld_q && !out_vld_q;
  assign in_ready_o = acc_ok && en;

`ifdef GAU_SYMM_EN
  assign rd_addr = AW'(gau_fold(int'(in_y_i), WIN) * (WIN / 2) + gau_fold(int'(in_x_i), WIN));
`else
  assign rd_addr = AW'(int'(in_y_i) * WIN + int'(in_x_i));
`endif

  gau_weight_tbl #(.NENT(NENT), .WW(WW), .AW(AW)) u_tbl (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (tbl_clr),
    .we_i    (tbl_we),
    .wdata_i (cfg_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_w),
    .wlast_o (tbl_wlast)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // A restart in LOAD wins over a same-cycle write.
  always_comb begin
    state_d      = state_q;
    tbl_clr      = 1'b0;
    tbl_we       = 1'b0;
    cfg_ready_o  = 1'b0;
    tbl_loaded_o = 1'b0;
    acc_ok       = 1'b0;
    unique case (state_q)
      EMPTY: if (cfg_start_i) begin
        state_d = LOAD;
        tbl_clr = 1'b1;
      end
      LOAD: begin
        cfg_ready_o = 1'b1;
        if (cfg_start_i) tbl_clr = 1'b1;
        else if (cfg_valid_i) begin
          tbl_we = 1'b1;
          if (tbl_wlast) state_d = READY;
        end
      end
      READY: begin
        tbl_loaded_o = 1'b1;
        acc_ok       = 1'b1;
        if (cfg_start_i) begin
          state_d = pipe_empty ? LOAD : DRAIN;
          tbl_clr = pipe_empty;
        end
      end
      DRAIN: if (pipe_empty) begin
        state_d = LOAD;
        tbl_clr = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Full-width product cannot overflow PW even with the rounding term added.
  assign prod       = PW'(s1_mag_q) * PW'(s1_w_q) + RND;
  assign out_data_d = prod[PW-1:SHIFT];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_w_q     <= '0;
      s1_mag_q   <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else if (en) begin
      s1_vld_q  <= in_valid_i && in_ready_o;
      out_vld_q <= s1_vld_q;
      if (in_valid_i && in_ready_o) begin
        s1_w_q    <= rd_w;
        s1_mag_q  <= in_mag_i;
        s1_last_q <= in_last_i;
      end
      if (s1_vld_q) begin
        out_data_q <= out_data_d;
        out_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_gau_weight_unit.sv
// Randomized self-checking bench for gau_weight_unit against a table-lookup reference model.
module tb_gau_weight_unit;
  localparam int WIN = 16, WW = 8, MW = 16, SHIFT = 4;
  localparam int XW = $clog2(WIN), OW = MW + WW - SHIFT;
`ifdef GAU_SYMM_EN
  localparam int NENT = (WIN / 2) * (WIN / 2);
`else
  localparam int NENT = WIN * WIN;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 0, cfg_valid = 0, cfg_ready, tbl_loaded;
  logic [WW-1:0] cfg_data = '0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [XW-1:0] in_x = '0, in_y = '0;
  logic [MW-1:0] in_mag = '0;
  logic out_valid, out_ready = 1'b1, out_last;
  logic [OW-1:0] out_data;

  int n_tests = 0, n_fail = 0;
  int mtbl[NENT];
  int qx[$], qy[$], qm[$];
  bit ql[$];

  gau_weight_unit #(.WIN(WIN), .WW(WW), .MW(MW), .SHIFT(SHIFT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_start_i(cfg_start), .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .tbl_loaded_o(tbl_loaded),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_y_i(in_y),
    .in_mag_i(in_mag), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Weight at window position (x, y) as the user sees it.
  function automatic int weight_at(input int x, input int y);
`ifdef GAU_SYMM_EN
    int h = WIN / 2;
    int xq = (x < h) ? x : WIN - 1 - x;
    int yq = (y < h) ? y : WIN - 1 - y;
    return mtbl[yq * h + xq];
`else
    return mtbl[y * WIN + x];
`endif
  endfunction

  function automatic longint model(input int x, input int y, input int mag);
    longint p = longint'(mag) * longint'(weight_at(x, y)) + (SHIFT > 0 ? (longint'(1) << (SHIFT - 1)) : 0);
    return p >> SHIFT;
  endfunction

  task automatic load_table();
    int k = 0, cyc = 0;
    @(negedge clk); cfg_start = 1;
    @(negedge clk); cfg_start = 0;
    while (k < NENT && cyc < 5000) begin
      cfg_valid = ($urandom_range(0, 3) != 0);
      cfg_data  = WW'(mtbl[k]);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL load_in_ready: got %b want 0", in_ready);
      end
      if (cfg_valid && cfg_ready === 1'b1) k++;
      @(negedge clk); cyc++;
    end
    cfg_valid = 0; in_valid = 0;
    #1;
    n_tests++;
    if (k != NENT || tbl_loaded !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_done: writes %0d/%0d tbl_loaded %b cfg_ready %b want 1/0", k, NENT, tbl_loaded, cfg_ready);
    end
  endtask

  task automatic test_lookup(input string nm, input int x, input int y, input int mag, input longint exp_d);
    @(negedge clk); out_ready = 1; in_valid = 1; in_x = XW'(x); in_y = XW'(y); in_mag = MW'(mag); in_last = 1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: in_ready %b want 1", nm, in_ready); end
    @(negedge clk); in_valid = 0; in_last = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid %b want 0 after 1 cycle", nm, out_valid); end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== OW'(exp_d) || out_last !== 1'b1) begin
      n_fail++; $display("FAIL %s: valid %b data %0d last %b want 1 %0d 1", nm, out_valid, out_data, out_last, exp_d);
    end
  endtask

  task automatic push_rand(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      qx.push_back($urandom_range(0, WIN - 1));
      qy.push_back($urandom_range(0, WIN - 1));
      qm.push_back($urandom_range(0, (1 << MW) - 1));
      ql.push_back(last_at_end ? (i == n - 1) : bit'($urandom_range(0, 1)));
    end
  endtask

  // mode 0: out_ready pattern 1,0,0,1; mode 1: random; otherwise always ready.
  task automatic run_stream(input string nm, input int mode);
    int n = qx.size();
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 0, hl = 0;
    logic [OW-1:0] hd = '0;
    longint ed[$];
    bit el[$];
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      case (mode)
        0: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1;
      endcase
      if (sent < n) begin
        in_valid = 1; in_x = XW'(qx[sent]); in_y = XW'(qy[sent]); in_mag = MW'(qm[sent]); in_last = ql[sent];
      end else begin
        in_valid = 0; in_last = 0;
      end
      #1;
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
          n_fail++; $display("FAIL %s_hold: valid %b data %0d last %b want 1 %0d %b", nm, out_valid, out_data, out_last, hd, hl);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_tests++;
        if (ed.size() == 0) begin
          n_fail++; $display("FAIL %s_extra: unexpected output %0d", nm, out_data);
        end else begin
          longint e = ed.pop_front();
          bit l = el.pop_front();
          if (out_data !== OW'(e) || out_last !== l) begin
            n_fail++; $display("FAIL %s_data[%0d]: data %0d last %b want %0d %b", nm, got, out_data, out_last, e, l);
          end
        end
        got++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      hd = out_data; hl = out_last;
      if (in_valid && in_ready === 1'b1) begin
        ed.push_back(model(qx[sent], qy[sent], qm[sent]));
        el.push_back(ql[sent]);
        sent++;
      end
      cyc++;
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (got != n || ed.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_count: got %0d of %0d, pending %0d, out_valid %b want 0", nm, got, n, ed.size(), out_valid);
    end
    qx.delete(); qy.delete(); qm.delete(); ql.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_x = 3; in_y = 2; in_mag = 100;
    #2;
    n_tests++;
    if (cfg_ready !== 0 || tbl_loaded !== 0 || in_ready !== 0 || out_valid !== 0 || out_data !== '0 || out_last !== 0) begin
      n_fail++; $display("FAIL reset_vals: cfg_ready %b tbl_loaded %b in_ready %b out_valid %b out_data %0d out_last %b want all 0",
                         cfg_ready, tbl_loaded, in_ready, out_valid, out_data, out_last);
    end
    @(negedge clk); rst_n = 1;
    repeat (4) begin
      @(negedge clk); #1;
      n_tests++;
      if (in_ready !== 0 || out_valid !== 0 || tbl_loaded !== 0 || cfg_ready !== 0) begin
        n_fail++; $display("FAIL reset_noload: in_ready %b out_valid %b tbl_loaded %b cfg_ready %b want 0", in_ready, out_valid, tbl_loaded, cfg_ready);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_single();
`ifdef GAU_SYMM_EN
    for (int k = 0; k < NENT; k++) mtbl[k] = k + 1;
    load_table();
    test_lookup("symm_00", 0, 0, 16, 1);
    test_lookup("symm_ff", 15, 15, 16, 1);
    test_lookup("symm_77", 7, 7, 16, 64);
    test_lookup("symm_88", 8, 8, 16, 64);
`else
    for (int k = 0; k < NENT; k++) mtbl[k] = k % 256;
    load_table();
    test_lookup("w35", 3, 2, 100, 219);
    test_lookup("w0", 0, 0, 1234, 0);
`endif
    test_lookup("maxmag", 15, 15, (1 << MW) - 1, model(15, 15, (1 << MW) - 1));
  endtask

  task automatic test_back_to_back();
    push_rand(16, 1'b1);
    run_stream("b2b", 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < NENT; k++) mtbl[k] = $urandom_range(0, (1 << WW) - 1);
    load_table();
    push_rand(40, 1'b0);
    run_stream("rand", 1);
  endtask

  task automatic test_drain_reload();
    longint ed[$];
    int got = 0, cyc = 0;
    int x0 = $urandom_range(0, WIN - 1), y0 = $urandom_range(0, WIN - 1), m0 = $urandom_range(1, 60000);
    int x1 = $urandom_range(0, WIN - 1), y1 = $urandom_range(0, WIN - 1), m1 = $urandom_range(1, 60000);
    for (int k = 0; k < NENT; k++) mtbl[k] = $urandom_range(1, (1 << WW) - 1);
    load_table();
    out_ready = 0;
    @(negedge clk); in_valid = 1; in_x = XW'(x0); in_y = XW'(y0); in_mag = MW'(m0); in_last = 0;
    #1; ed.push_back(model(x0, y0, m0));
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_acc0: in_ready %b want 1", in_ready); end
    @(negedge clk); in_x = XW'(x1); in_y = XW'(y1); in_mag = MW'(m1);
    #1; ed.push_back(model(x1, y1, m1));
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_acc1: in_ready %b want 1", in_ready); end
    @(negedge clk); in_valid = 0; cfg_start = 1;
    @(negedge clk); cfg_start = 0;
    #1;
    n_tests++;
    if (tbl_loaded !== 0 || in_ready !== 0 || cfg_ready !== 0 || out_valid !== 1) begin
      n_fail++; $display("FAIL drain_state: tbl_loaded %b in_ready %b cfg_ready %b out_valid %b want 0 0 0 1", tbl_loaded, in_ready, cfg_ready, out_valid);
    end
    @(negedge clk); cfg_start = 1; in_valid = 1; out_ready = 1;
    while (!(got == 2 && cfg_ready === 1'b1) && cyc < 50) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_refuse: in_ready %b want 0", in_ready); end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (ed.size() == 0) begin
          n_fail++; $display("FAIL drain_extra: unexpected output %0d", out_data);
        end else begin
          longint e = ed.pop_front();
          if (out_data !== OW'(e) || cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL drain_out[%0d]: data %0d cfg_ready %b want %0d 0", got, out_data, cfg_ready, e);
          end
        end
        got++;
      end
      @(negedge clk); cfg_start = 0; cyc++;
    end
    n_tests++;
    if (got != 2 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_to_load: outputs %0d want 2, cfg_ready %b want 1", got, cfg_ready);
    end
    for (int k = 0; k < NENT; k++) mtbl[k] = $urandom_range(0, (1 << WW) - 1);
    load_table();
    push_rand(12, 1'b0);
    run_stream("newtbl", 2);
  endtask

  task automatic test_reset_midload();
    @(negedge clk); cfg_start = 1;
    @(negedge clk); cfg_start = 0; cfg_valid = 1;
    for (int i = 0; i < 100; i++) begin
      cfg_data = WW'($urandom_range(0, 255));
      @(negedge clk);
    end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (cfg_ready !== 0 || tbl_loaded !== 0 || in_ready !== 0 || out_valid !== 0 || out_data !== '0 || out_last !== 0) begin
      n_fail++; $display("FAIL midload_reset: cfg_ready %b tbl_loaded %b in_ready %b out_valid %b data %0d last %b want all 0",
                         cfg_ready, tbl_loaded, in_ready, out_valid, out_data, out_last);
    end
    cfg_valid = 0;
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < NENT; k++) mtbl[k] = $urandom_range(0, (1 << WW) - 1);
    load_table();
    push_rand(10, 1'b1);
    run_stream("reload", 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_drain_reload();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
